pfpu_wbtrack: RTL and testbench
===============================

Name: pfpu_wbtrack

Overview:
- Writeback/tracking stage directly downstream of the PFPU ALUs, including the 1-cycle copy unit.
- Records each issued operation's destination register and latency in a delay line.
- Pairs each entry with the ALU result valid/data returned exactly that many cycles later, and drives the register-file write port.
- Keeps a per-register pending scoreboard so the issue logic stalls on read-after-write, write-after-write and writeback-slot hazards.

Parameters:
- ADDR_W, 7: register address width (128 registers).
- MAX_LAT, 8: largest supported ALU latency in cycles (≥2).
- LAT_W, 4: width of the issue latency field; must hold MAX_LAT.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- flush_i  in  1  synchronous abort of all tracked operations.
- issue_i  in  1  issue logic presents an operation this cycle.
- issue_dest_i  in  ADDR_W  destination register.
- issue_lat_i  in  LAT_W  ALU latency of the op (copy unit = 1).
- issue_srca_i  in  ADDR_W  source operand A address.
- issue_srcb_i  in  ADDR_W  source operand B address.
- issue_ok_o  out  1  combinational: an issue this cycle is accepted.
- alu_valid_i  in  1  OR of all ALU valid outputs.
- alu_r_i  in  32  muxed ALU result.
- regf_we_o  out  1  register-file write enable.
- regf_waddr_o  out  ADDR_W  write address.
- regf_wdat_o  out  32  write data.
- busy_o  out  1  any slot valid or write pending.
- err_o  out  1  sticky protocol-mismatch flag.

Behaviour:
- Slot array s[1..MAX_LAT], each entry {valid, addr}; pending[0..2^ADDR_W-1] bit vector.
- Every edge: s[k] <= s[k+1] for k < MAX_LAT; s[MAX_LAT] <= invalid.
- Accepted issue at cycle t with latency L: s[L] <= {1, dest}, written after the shift. pending[dest] <= 1.
- Head s[1] is valid exactly in cycle t+L. alu_valid_i is required high in that same cycle.
- issue_ok_o = issue_i AND 1 ≤ L ≤ MAX_LAT AND !pending[dest] AND !pending[srca] AND !pending[srcb] AND (L == MAX_LAT OR !s[L+1].valid) AND !flush_i.
  - The s[L+1] term rejects a writeback-slot collision.
  - L == 0 or L > MAX_LAT is never accepted.
- Retire, in cycle t+L:
  - s[1].valid AND alu_valid_i: at the edge, regf_we_o <= 1, regf_waddr_o <= s[1].addr, regf_wdat_o <= alu_r_i. Write is visible in cycle t+L+1.
  - Otherwise regf_we_o <= 0. regf_waddr_o and regf_wdat_o hold their last values.
- pending[a] clears on the edge that ends a cycle with regf_we_o = 1 and regf_waddr_o = a. A dependent op can therefore issue at t+L+2 at the earliest.
- Mismatch (s[1].valid XOR alu_valid_i):
  - err_o <= 1 (sticky).
  - No write occurs.
  - If the head was valid, its pending bit clears on the following edge, as if it had been written.
  - err_o clears only on reset.
- Same-register set and clear in one cycle cannot occur, because a pending dest blocks issue. If it does occur, set wins.
- flush_i: at the edge, all slots are invalidated, all pending bits and regf_we_o are cleared, and any concurrent issue is ignored. err_o is held.
- busy_o = OR(s[*].valid) OR regf_we_o OR OR(pending).
- Reset values: all slots invalid, pending all 0, regf_we_o = 0, regf_waddr_o = 0, regf_wdat_o = 0, err_o = 0.
  - issue_ok_o and busy_o follow from state, so both are 0 while in reset.
- Asserting reset mid-operation discards all in-flight entries without any write.

Optional Feature:
- Macro PFPU_WBTRACK_STATS_EN.
- Defined: adds output wb_count_o[31:0], reset to 0, incremented on each edge where regf_we_o = 1. It wraps from 0xFFFFFFFF to 0 and is cleared by flush_i.
- Undefined: the port and the counter are absent; everything else is identical.

Test Plan:
- Copy op: issue dest=5, L=1, srcs 0/1 at cycle 0; alu_valid_i=1, alu_r_i=0x3F800000 at cycle 1 → regf_we_o=1, waddr=5, wdat=0x3F800000 in cycle 2; pending[5] clear from cycle 3; err_o=0.
- RAW stall: after the op above, issue srca=5 in cycles 1–2 → issue_ok_o=0; the same issue in cycle 3 → issue_ok_o=1.
- Slot collision: issue L=3 dest=2 at cycle 0, then L=2 dest=3 at cycle 1 → rejected; L=2 dest=3 at cycle 2 → accepted; writes to reg 2 in cycle 4 and reg 3 in cycle 5.
- Mismatch: issue L=4 dest=9 with alu_valid_i low in cycle 4 → no write, err_o=1 from cycle 5 and still 1 after later good ops; pending[9] clears.
- Flush/reset: three ops in flight, pulse flush_i → no regf_we_o afterwards, busy_o=0 next cycle; repeat with sys_rst_n low → same result, err_o=0.
- Bounds: issue with L=0 or L=9 → issue_ok_o=0; L=8 with dest=127 → accepted, write in cycle 9.

Source files
------------

// File: rtl/pfpu_wbtrack.sv
// PFPU writeback/tracking stage: latency delay line, register-file write port, pending scoreboard.
// Optional writeback counter (wb_count_o) enabled by defining PFPU_WBTRACK_STATS_EN.
module pfpu_wbtrack #(
  parameter int ADDR_W  = 7,
  parameter int MAX_LAT = 8,
  parameter int LAT_W   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              flush_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_dest_i,
  input  logic [LAT_W-1:0]  issue_lat_i,
  input  logic [ADDR_W-1:0] issue_srca_i,
  input  logic [ADDR_W-1:0] issue_srcb_i,
  output logic              issue_ok_o,
  input  logic              alu_valid_i,
  input  logic [31:0]       alu_r_i,
  output logic              regf_we_o,
  output logic [ADDR_W-1:0] regf_waddr_o,
  output logic [31:0]       regf_wdat_o,
  output logic              busy_o,
  output logic              err_o
`ifdef PFPU_WBTRACK_STATS_EN
  ,
  output logic [31:0]       wb_count_o
`endif
);

  localparam int NREG = 1 << ADDR_W;

  logic [MAX_LAT:1]  slot_vld_r;
  logic [ADDR_W-1:0] slot_addr_r [1:MAX_LAT];
  logic [NREG-1:0]   pend_r;
  logic [NREG-1:0]   pend_nxt_s;
  logic              miss_clr_r;
  logic [ADDR_W-1:0] miss_addr_r;
  logic              lat_ok_s;
  logic              collide_s;
  logic              hazard_s;
  logic              head_vld_s;

  assign head_vld_s = slot_vld_r[1];

  // Issue acceptance: latency range, scoreboard hazards and writeback-slot collision.
  always_comb begin
    lat_ok_s  = (issue_lat_i >= LAT_W'(1)) && (issue_lat_i <= LAT_W'(MAX_LAT));
    collide_s = 1'b0;
    for (int k = 1; k < MAX_LAT; k++) begin
      if (slot_vld_r[k+1] && (int'(issue_lat_i) == k)) begin
        collide_s = 1'b1;
      end else begin
        collide_s = collide_s;
      end
    end
    hazard_s   = pend_r[issue_dest_i] | pend_r[issue_srca_i] | pend_r[issue_srcb_i];
    issue_ok_o = issue_i && lat_ok_s && !hazard_s && !collide_s && !flush_i;
  end

  // Scoreboard next state; a set in the same cycle as a clear wins.
  always_comb begin
    pend_nxt_s = pend_r;
    if (regf_we_o) begin
      pend_nxt_s[regf_waddr_o] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (miss_clr_r) begin
      pend_nxt_s[miss_addr_r] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (issue_ok_o) begin
      pend_nxt_s[issue_dest_i] = 1'b1;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
  end

  // Delay line shift/insert, retire to the register file and mismatch tracking.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slot_vld_r   <= '0;
      for (int k = 1; k <= MAX_LAT; k++) slot_addr_r[k] <= '0;
      pend_r       <= '0;
      miss_clr_r   <= 1'b0;
      miss_addr_r  <= '0;
      regf_we_o    <= 1'b0;
      regf_waddr_o <= '0;
      regf_wdat_o  <= 32'd0;
      err_o        <= 1'b0;
    end else if (flush_i) begin
      slot_vld_r <= '0;
      pend_r     <= '0;
      miss_clr_r <= 1'b0;
      regf_we_o  <= 1'b0;
    end else begin
      for (int k = 1; k < MAX_LAT; k++) begin
        slot_vld_r[k]  <= slot_vld_r[k+1];
        slot_addr_r[k] <= slot_addr_r[k+1];
      end
      slot_vld_r[MAX_LAT] <= 1'b0;
      if (issue_ok_o) begin
        slot_vld_r[issue_lat_i]  <= 1'b1;
        slot_addr_r[issue_lat_i] <= issue_dest_i;
      end
      regf_we_o <= head_vld_s & alu_valid_i;
      if (head_vld_s & alu_valid_i) begin
        regf_waddr_o <= slot_addr_r[1];
        regf_wdat_o  <= alu_r_i;
      end
      if (head_vld_s ^ alu_valid_i) begin
        err_o <= 1'b1;
      end
      // A valid head with no ALU result releases its scoreboard bit one cycle later, like a write.
      miss_clr_r  <= head_vld_s & ~alu_valid_i;
      miss_addr_r <= slot_addr_r[1];
      pend_r      <= pend_nxt_s;
    end
  end

  assign busy_o = (|slot_vld_r) | regf_we_o | (|pend_r);

`ifdef PFPU_WBTRACK_STATS_EN
  // Count of completed register-file writes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wb_count_o <= 32'd0;
    end else if (flush_i) begin
      wb_count_o <= 32'd0;
    end else if (regf_we_o) begin
      wb_count_o <= wb_count_o + 32'd1;
    end else begin
      wb_count_o <= wb_count_o;
    end
  end
`endif

endmodule

// File: tb/tb_pfpu_wbtrack.sv
// Bench for pfpu_wbtrack: directed vector table, flush/reset sequences and randomized traffic
// checked against an op-list reference model (each op tracked by destination and due cycle).
module tb_pfpu_wbtrack;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        flush_i;
  logic        issue_i;
  logic [6:0]  issue_dest_i;
  logic [3:0]  issue_lat_i;
  logic [6:0]  issue_srca_i;
  logic [6:0]  issue_srcb_i;
  logic        issue_ok_o;
  logic        alu_valid_i;
  logic [31:0] alu_r_i;
  logic        regf_we_o;
  logic [6:0]  regf_waddr_o;
  logic [31:0] regf_wdat_o;
  logic        busy_o;
  logic        err_o;

  pfpu_wbtrack dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .flush_i      (flush_i),
    .issue_i      (issue_i),
    .issue_dest_i (issue_dest_i),
    .issue_lat_i  (issue_lat_i),
    .issue_srca_i (issue_srca_i),
    .issue_srcb_i (issue_srcb_i),
    .issue_ok_o   (issue_ok_o),
    .alu_valid_i  (alu_valid_i),
    .alu_r_i      (alu_r_i),
    .regf_we_o    (regf_we_o),
    .regf_waddr_o (regf_waddr_o),
    .regf_wdat_o  (regf_wdat_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 sys_clk = ~sys_clk;

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: list of in-flight ops; an op is pending until its due cycle + 1.
  typedef struct {
    int dest;
    int due;
  } op_t;

  op_t         ops[$];
  int          cyc;
  logic        m_we;
  logic [6:0]  m_waddr;
  logic [31:0] m_wdat;
  logic        m_err;

  logic        s_ok, s_we, s_err, s_busy;
  logic [6:0]  s_waddr;
  logic [31:0] s_wdat;

  function automatic logic m_ok(logic iss, int dest, int lat, int sa, int sb, logic fl);
    if (!iss || fl || lat < 1 || lat > 8) return 1'b0;
    foreach (ops[i]) begin
      if (ops[i].dest == dest || ops[i].dest == sa || ops[i].dest == sb) return 1'b0;
      if (ops[i].due == cyc + lat) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int m_head();
    foreach (ops[i]) if (ops[i].due == cyc) return ops[i].dest;
    return -1;
  endfunction

  task automatic model_reset();
    ops.delete();
    m_we    = 1'b0;
    m_waddr = 7'd0;
    m_wdat  = 32'd0;
    m_err   = 1'b0;
  endtask

  task automatic do_cycle(input logic iss, input int dest, input int lat, input int sa, input int sb,
                          input logic fl, input logic av, input logic [31:0] ar);
    logic ok_e;
    int   hd;
    issue_i      = iss;
    issue_dest_i = dest[6:0];
    issue_lat_i  = lat[3:0];
    issue_srca_i = sa[6:0];
    issue_srcb_i = sb[6:0];
    flush_i      = fl;
    alu_valid_i  = av;
    alu_r_i      = ar;
    @(negedge sys_clk);
    ok_e    = m_ok(iss, dest, lat, sa, sb, fl);
    s_ok    = issue_ok_o;
    s_we    = regf_we_o;
    s_waddr = regf_waddr_o;
    s_wdat  = regf_wdat_o;
    s_err   = err_o;
    s_busy  = busy_o;
    check("model_issue_ok", 32'(s_ok), 32'(ok_e));
    check("model_we", 32'(s_we), 32'(m_we));
    check("model_waddr", 32'(s_waddr), 32'(m_waddr));
    check("model_wdat", s_wdat, m_wdat);
    check("model_err", 32'(s_err), 32'(m_err));
    check("model_busy", 32'(s_busy), 32'((ops.size() != 0) || m_we));
    @(posedge sys_clk);
    if (fl) begin
      ops.delete();
      m_we = 1'b0;
    end else begin
      hd   = m_head();
      m_we = (hd >= 0) && av;
      if (m_we) begin
        m_waddr = hd[6:0];
        m_wdat  = ar;
      end
      if ((hd >= 0) != av) m_err = 1'b1;
      for (int i = ops.size() - 1; i >= 0; i--) if (ops[i].due < cyc) ops.delete(i);
      if (ok_e) ops.push_back('{dest, cyc + lat});
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    issue_i     = 1'b0;
    flush_i     = 1'b0;
    alu_valid_i = 1'b0;
    sys_rst_n   = 1'b0;
    model_reset();
    @(negedge sys_clk);
    check("rst_issue_ok", 32'(issue_ok_o), 32'd0);
    check("rst_we", 32'(regf_we_o), 32'd0);
    check("rst_waddr", 32'(regf_waddr_o), 32'd0);
    check("rst_wdat", regf_wdat_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    cyc++;
  endtask

  typedef struct {
    logic        iss;
    int          dest, lat, sa, sb;
    logic        av;
    logic [31:0] ar;
    logic        ok, we;
    int          wa;
    logic [31:0] wd;
    logic        err, busy;
  } vec_t;

  vec_t tbl[37];

  task automatic row(input int i, input logic iss, input int dest, input int lat, input int sa,
                     input int sb, input logic av, input logic [31:0] ar, input logic ok,
                     input logic we, input int wa, input logic [31:0] wd, input logic err,
                     input logic busy);
    tbl[i] = '{iss, dest, lat, sa, sb, av, ar, ok, we, wa, wd, err, busy};
  endtask

  initial begin
    int av_r;
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    sys_clk      = 1'b0;
    sys_rst_n    = 1'b0;
    flush_i      = 1'b0;
    issue_i      = 1'b0;
    issue_dest_i = 7'd0;
    issue_lat_i  = 4'd0;
    issue_srca_i = 7'd0;
    issue_srcb_i = 7'd0;
    alu_valid_i  = 1'b0;
    alu_r_i      = 32'd0;

    // copy op and RAW stall
    row(0,  1, 5, 1, 0, 1,  0, 32'h0,        1, 0, 0, 32'h0, 0, 0);
    row(1,  1, 6, 1, 5, 1,  1, 32'h3F800000, 0, 0, 0, 32'h0, 0, 1);
    row(2,  1, 6, 1, 5, 1,  0, 32'h0,        0, 1, 5, 32'h3F800000, 0, 1);
    row(3,  1, 6, 1, 5, 1,  0, 32'h0,        1, 0, 0, 32'h0, 0, 0);
    row(4,  0, 0, 0, 0, 0,  1, 32'h40000000, 0, 0, 0, 32'h0, 0, 1);
    row(5,  0, 0, 0, 0, 0,  0, 32'h0,        0, 1, 6, 32'h40000000, 0, 1);
    row(6,  0, 0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 32'h0, 0, 0);
    // writeback-slot collision
    row(7,  1, 2, 3, 10, 11, 0, 32'h0,       1, 0, 0, 32'h0, 0, 0);
    row(8,  1, 3, 2, 10, 11, 0, 32'h0,       0, 0, 0, 32'h0, 0, 1);
    row(9,  1, 3, 2, 10, 11, 0, 32'h0,       1, 0, 0, 32'h0, 0, 1);
    row(10, 0, 0, 0, 0, 0,  1, 32'h22,       0, 0, 0, 32'h0, 0, 1);
    row(11, 0, 0, 0, 0, 0,  1, 32'h33,       0, 1, 2, 32'h22, 0, 1);
    row(12, 0, 0, 0, 0, 0,  0, 32'h0,        0, 1, 3, 32'h33, 0, 1);
    row(13, 0, 0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 32'h0, 0, 0);
    // mismatch: head valid without ALU result
    row(14, 1, 9, 4, 0, 0,  0, 32'h0,        1, 0, 0, 32'h0, 0, 0);
    row(15, 0, 0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 32'h0, 0, 1);
    row(16, 0, 0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 32'h0, 0, 1);
    row(17, 0, 0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 32'h0, 0, 1);
    row(18, 0, 0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 32'h0, 0, 1);
    row(19, 1, 9, 1, 0, 0,  0, 32'h0,        0, 0, 0, 32'h0, 1, 1);
    row(20, 1, 9, 1, 0, 0,  0, 32'h0,        1, 0, 0, 32'h0, 1, 0);
    row(21, 0, 0, 0, 0, 0,  1, 32'h99,       0, 0, 0, 32'h0, 1, 1);
    row(22, 0, 0, 0, 0, 0,  0, 32'h0,        0, 1, 9, 32'h99, 1, 1);
    row(23, 0, 0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 32'h0, 1, 0);
    // latency bounds
    row(24, 1, 1, 0, 2, 3,  0, 32'h0,        0, 0, 0, 32'h0, 1, 0);
    row(25, 1, 1, 9, 2, 3,  0, 32'h0,        0, 0, 0, 32'h0, 1, 0);
    row(26, 1, 127, 8, 0, 0, 0, 32'h0,       1, 0, 0, 32'h0, 1, 0);
    for (int i = 27; i <= 33; i++) row(i, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 1, 1);
    row(34, 0, 0, 0, 0, 0,  1, 32'h7F7F7F7F, 0, 0, 0, 32'h0, 1, 1);
    row(35, 0, 0, 0, 0, 0,  0, 32'h0,        0, 1, 127, 32'h7F7F7F7F, 1, 1);
    row(36, 0, 0, 0, 0, 0,  0, 32'h0,        0, 0, 0, 32'h0, 1, 0);

    #1;
    do_reset();

    for (int i = 0; i < 37; i++) begin
      do_cycle(tbl[i].iss, tbl[i].dest, tbl[i].lat, tbl[i].sa, tbl[i].sb, 1'b0, tbl[i].av, tbl[i].ar);
      check($sformatf("vec%0d_issue_ok", i), 32'(s_ok), 32'(tbl[i].ok));
      check($sformatf("vec%0d_we", i), 32'(s_we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        check($sformatf("vec%0d_waddr", i), 32'(s_waddr), tbl[i].wa);
        check($sformatf("vec%0d_wdat", i), s_wdat, tbl[i].wd);
      end
      check($sformatf("vec%0d_err", i), 32'(s_err), 32'(tbl[i].err));
      check($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
    end

    // flush with three ops in flight
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 20 + i, 5 + i, 0, 0, 1'b0, 1'b0, 32'h0);
      check("flush_setup_ok", 32'(s_ok), 32'd1);
    end
    do_cycle(1'b1, 23, 1, 0, 0, 1'b1, 1'b0, 32'h0);
    check("flush_issue_ok", 32'(s_ok), 32'd0);
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 32'h0);
      check("post_flush_we", 32'(s_we), 32'd0);
      check("post_flush_busy", 32'(s_busy), 32'd0);
      check("post_flush_err", 32'(s_err), 32'd1);
    end

    // reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b1, 30 + i, 3 + i, 0, 0, 1'b0, 1'b0, 32'h0);
      check("reset_setup_ok", 32'(s_ok), 32'd1);
    end
    do_reset();
    for (int i = 0; i < 10; i++) begin
      do_cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 32'h0);
      check("post_reset_we", 32'(s_we), 32'd0);
      check("post_reset_busy", 32'(s_busy), 32'd0);
      check("post_reset_err", 32'(s_err), 32'd0);
    end

    // randomized traffic with occasional mismatches, flushes and one reset
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) do_reset();
      av_r = (m_head() >= 0) ? 1 : 0;
      if ($urandom_range(0, 29) == 0) av_r = 1 - av_r;
      do_cycle($urandom_range(0, 9) < 6, $urandom_range(0, 15), $urandom_range(0, 10),
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 99) == 0,
               av_r != 0, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
